// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_if
//  Description : Bus bundle for the renaming register file: two combinational
//                read ports, one rename port and the result-broadcast port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if;
    // Read ports
    logic [4:0]  ReadAddr1;
    logic [4:0]  ReadAddr2;
    logic [31:0] DataOut1;
    logic [31:0] DataOut2;
    logic [4:0]  LabelOut1;
    logic [4:0]  LabelOut2;
    // Rename port
    logic        RegWr;
    logic [4:0]  WriteAddr;
    logic [4:0]  WriteLabel;
    // Result broadcast (common data bus)
    logic        BCEN;
    logic [4:0]  BClabel;
    logic [31:0] BCdata;

    // Requester side: issues reads, renames and broadcasts
    modport master (
        output ReadAddr1, ReadAddr2,
        output RegWr, WriteAddr, WriteLabel,
        output BCEN, BClabel, BCdata,
        input  DataOut1, DataOut2, LabelOut1, LabelOut2
    );

    // Register file side
    modport slave (
        input  ReadAddr1, ReadAddr2,
        input  RegWr, WriteAddr, WriteLabel,
        input  BCEN, BClabel, BCdata,
        output DataOut1, DataOut2, LabelOut1, LabelOut2
    );
endinterface
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 32 x 32-bit register file with 5-bit producer labels for
//                register renaming. Broadcast results wake every waiting
//                register and are bypassed onto the read ports in-cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file (
    input  wire logic   clk,
    input  wire logic   RST,
    reg_file_if.slave   bus
);
    localparam int c_NUM_REGS = 32;

    logic [31:0] data_q  [c_NUM_REGS];
    logic [31:0] data_d  [c_NUM_REGS];
    logic [4:0]  label_q [c_NUM_REGS];
    logic [4:0]  label_d [c_NUM_REGS];

    // Label 0 means "no producer", so a broadcast of label 0 carries nothing
    logic w_bc_valid;
    assign w_bc_valid = bus.BCEN && (bus.BClabel != 5'd0);

    // Next state: broadcast wakes matching registers, then a rename overrides
    // the label so a new producer wins over the value just delivered.
    always_comb begin
        for (int i = 0; i < c_NUM_REGS; i++) begin
            data_d[i]  = data_q[i];
            label_d[i] = label_q[i];
        end
        if (w_bc_valid) begin
            for (int i = 1; i < c_NUM_REGS; i++) begin
                if (label_q[i] == bus.BClabel) begin
                    data_d[i]  = bus.BCdata;
                    label_d[i] = 5'd0;
                end
            end
        end
        if (bus.RegWr && (bus.WriteAddr != 5'd0)) begin
            label_d[bus.WriteAddr] = bus.WriteLabel;
        end
        // Register 0 is hardwired to a valid zero
        data_d[0]  = 32'd0;
        label_d[0] = 5'd0;
    end

    // Register array update with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                data_q[i]  <= 32'd0;
                label_q[i] <= 5'd0;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                data_q[i]  <= data_d[i];
                label_q[i] <= label_d[i];
            end
        end
    end

    // Read port 1 with broadcast bypass (register 0 never matches: label 0)
    always_comb begin
        bus.DataOut1  = data_q[bus.ReadAddr1];
        bus.LabelOut1 = label_q[bus.ReadAddr1];
        if (w_bc_valid && (label_q[bus.ReadAddr1] == bus.BClabel)) begin
            bus.DataOut1  = bus.BCdata;
            bus.LabelOut1 = 5'd0;
        end
    end

    // Read port 2 with broadcast bypass
    always_comb begin
        bus.DataOut2  = data_q[bus.ReadAddr2];
        bus.LabelOut2 = label_q[bus.ReadAddr2];
        if (w_bc_valid && (label_q[bus.ReadAddr2] == bus.BClabel)) begin
            bus.DataOut2  = bus.BCdata;
            bus.LabelOut2 = 5'd0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Self-checking bench for reg_file: directed scenarios with
//                literal expectations, then randomized traffic against a
//                behavioural model of the renaming register file.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;
    logic clk;
    logic RST;
    int   tests;
    int   fails;
    bit   chk_en;

    reg_file_if bus ();

    reg_file dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: what each architectural register currently holds
    logic [31:0] m_data  [32];
    logic [4:0]  m_label [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_data[i]  = 32'd0;
            m_label[i] = 5'd0;
        end
    end

    // Model state update on each rising edge
    always @(posedge clk) begin
        logic [31:0] nd [32];
        logic [4:0]  nl [32];
        for (int r = 0; r < 32; r++) begin
            nd[r] = m_data[r];
            nl[r] = m_label[r];
        end
        if (RST) begin
            for (int r = 0; r < 32; r++) begin
                nd[r] = 32'd0;
                nl[r] = 5'd0;
            end
        end else begin
            if (bus.BCEN && bus.BClabel != 0) begin
                for (int r = 1; r < 32; r++)
                    if (m_label[r] == bus.BClabel) begin
                        nd[r] = bus.BCdata;
                        nl[r] = 5'd0;
                    end
            end
            if (bus.RegWr && bus.WriteAddr != 0)
                nl[bus.WriteAddr] = bus.WriteLabel;
        end
        for (int r = 0; r < 32; r++) begin
            m_data[r]  <= nd[r];
            m_label[r] <= nl[r];
        end
    end

    // What a read of register a should show right now, bypass included
    function automatic logic [36:0] model_read(input logic [4:0] a);
        if (bus.BCEN && bus.BClabel != 0 && m_label[a] == bus.BClabel)
            return {bus.BCdata, 5'd0};
        return {m_data[a], m_label[a]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, both ports against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [36:0] e1;
            logic [36:0] e2;
            e1 = model_read(bus.ReadAddr1);
            e2 = model_read(bus.ReadAddr2);
            check("model_port1", {bus.DataOut1, 5'd0} | {32'd0, bus.LabelOut1}, 32'd0 | {e1[36:5], 5'd0} | {27'd0, e1[4:0]});
            check("model_port2", {bus.DataOut2, 5'd0} | {32'd0, bus.LabelOut2}, 32'd0 | {e2[36:5], 5'd0} | {27'd0, e2[4:0]});
            check("model_data1", bus.DataOut1, e1[36:5]);
            check("model_data2", bus.DataOut2, e2[36:5]);
        end
    end

    task automatic idle();
        bus.RegWr      = 1'b0;
        bus.WriteAddr  = 5'd0;
        bus.WriteLabel = 5'd0;
        bus.BCEN       = 1'b0;
        bus.BClabel    = 5'd0;
        bus.BCdata     = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] a, input logic [4:0] l);
        idle();
        bus.RegWr      = 1'b1;
        bus.WriteAddr  = a;
        bus.WriteLabel = l;
        tick();
        idle();
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 1'b0;
        RST    = 1'b1;
        bus.ReadAddr1 = 5'd0;
        bus.ReadAddr2 = 5'd0;
        idle();
        tick();
        tick();
        RST    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        bus.ReadAddr1 = 5'd1;
        bus.ReadAddr2 = 5'd2;
        @(negedge clk);
        check("rst_data1",  bus.DataOut1,  32'd0);
        check("rst_label1", {27'd0, bus.LabelOut1}, 32'd0);
        check("rst_data2",  bus.DataOut2,  32'd0);
        check("rst_label2", {27'd0, bus.LabelOut2}, 32'd0);

        // Rename reg 2 -> label 3 (not visible until after the edge)
        tick();
        bus.RegWr = 1'b1; bus.WriteAddr = 5'd2; bus.WriteLabel = 5'd3;
        bus.ReadAddr1 = 5'd2;
        @(negedge clk);
        check("rename_no_bypass", {27'd0, bus.LabelOut1}, 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("rename_label", {27'd0, bus.LabelOut1}, 32'd3);
        check("rename_data",  bus.DataOut1, 32'd0);

        // Broadcast label 3: bypass in-cycle, then stored
        tick();
        bus.BCEN = 1'b1; bus.BClabel = 5'd3; bus.BCdata = 32'd10;
        bus.ReadAddr2 = 5'd4;
        @(negedge clk);
        check("bypass_data",  bus.DataOut1, 32'd10);
        check("bypass_label", {27'd0, bus.LabelOut1}, 32'd0);
        check("bypass_other", bus.DataOut2, 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("bc_stored_data",  bus.DataOut1, 32'd10);
        check("bc_stored_label", {27'd0, bus.LabelOut1}, 32'd0);
        check("bc_unaffected",   bus.DataOut2, 32'd0);

        // Multiple registers woken by one broadcast
        tick();
        rename(5'd5, 5'd7);
        rename(5'd6, 5'd7);
        bus.BCEN = 1'b1; bus.BClabel = 5'd7; bus.BCdata = 32'hDEADBEEF;
        tick();
        idle();
        bus.ReadAddr1 = 5'd5;
        bus.ReadAddr2 = 5'd6;
        @(negedge clk);
        check("multi_data5",  bus.DataOut1, 32'hDEADBEEF);
        check("multi_data6",  bus.DataOut2, 32'hDEADBEEF);
        check("multi_label6", {27'd0, bus.LabelOut2}, 32'd0);

        // Rename and matching broadcast on the same edge: new producer wins
        tick();
        rename(5'd5, 5'd7);
        bus.RegWr = 1'b1; bus.WriteAddr = 5'd5; bus.WriteLabel = 5'd9;
        bus.BCEN  = 1'b1; bus.BClabel   = 5'd7; bus.BCdata     = 32'd4;
        tick();
        idle();
        @(negedge clk);
        check("collide_data",  bus.DataOut1, 32'd4);
        check("collide_label", {27'd0, bus.LabelOut1}, 32'd9);

        // Register 0 ignores renames and broadcasts
        tick();
        rename(5'd0, 5'd3);
        bus.BCEN = 1'b1; bus.BClabel = 5'd3; bus.BCdata = 32'd55;
        bus.ReadAddr1 = 5'd0;
        @(negedge clk);
        check("r0_bypass_data", bus.DataOut1, 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("r0_data",  bus.DataOut1, 32'd0);
        check("r0_label", {27'd0, bus.LabelOut1}, 32'd0);

        // Broadcast of label 0 is ignored (reg 8 holds label 0)
        tick();
        bus.BCEN = 1'b1; bus.BClabel = 5'd0; bus.BCdata = 32'd77;
        bus.ReadAddr1 = 5'd8;
        @(negedge clk);
        check("bc_label0_bypass", bus.DataOut1, 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("bc_label0_store", bus.DataOut1, 32'd0);

        // Reset beats a simultaneous rename and broadcast
        tick();
        RST = 1'b1;
        bus.RegWr = 1'b1; bus.WriteAddr = 5'd3; bus.WriteLabel = 5'd5;
        bus.BCEN  = 1'b1; bus.BClabel   = 5'd9; bus.BCdata     = 32'd123;
        tick();
        RST = 1'b0;
        idle();
        bus.ReadAddr1 = 5'd5;
        bus.ReadAddr2 = 5'd3;
        @(negedge clk);
        check("rst_mid_data5",  bus.DataOut1, 32'd0);
        check("rst_mid_label5", {27'd0, bus.LabelOut1}, 32'd0);
        check("rst_mid_label3", {27'd0, bus.LabelOut2}, 32'd0);

        // Randomized traffic; small label range makes matches frequent
        for (int n = 0; n < 3000; n++) begin
            tick();
            RST            = ($urandom_range(0, 199) == 0);
            bus.ReadAddr1  = 5'($urandom_range(0, 31));
            bus.ReadAddr2  = 5'($urandom_range(0, 31));
            bus.RegWr      = ($urandom_range(0, 1) == 1);
            bus.WriteAddr  = 5'($urandom_range(0, 31));
            bus.WriteLabel = 5'($urandom_range(0, 6));
            bus.BCEN       = ($urandom_range(0, 2) != 0);
            bus.BClabel    = 5'($urandom_range(0, 6));
            bus.BCdata     = $urandom;
        end
        tick();
        RST = 1'b0;
        idle();
        @(negedge clk);
        @(posedge clk);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
